// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM OPI transaction engine.
//   - state_e      : frame sequencer states
//   - *_BEATS      : fixed beat counts of the frame phases
//   - MIN_PSCR     : smallest usable prescaler (one beat = 2 clocks)
//   - beatLen()    : clamps a raw prescaler value to a legal beat length
package psram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WAIT,
        DATA,
        RECOV
    } state_e;

    localparam logic [8:0] CMD_BEATS   = 9'd2;
    localparam logic [8:0] ADDR_BEATS  = 9'd4;
    localparam logic [8:0] DATA_BEATS  = 9'd4;
    localparam logic [8:0] RECOV_BEATS = 9'd2;

    localparam logic [7:0] MIN_PSCR = 8'd2;

    // A beat needs at least two clocks so SCK can toggle mid-beat.
    function automatic logic [7:0] beatLen(input logic [7:0] pscr);
        return (pscr < MIN_PSCR) ? MIN_PSCR : pscr;
    endfunction

endpackage

// File: rtl/psram_beat_gen.sv
// Beat timing generator for the PSRAM OPI engine.
// Counts clocks inside a beat of beat_len_i cycles while active_i is high.
//   clk_i, rst_i   : clock, async active-high reset
//   active_i       : frame in progress; counter held at 0 otherwise
//   beat_len_i     : latched beat length P (>= 2)
//   beat_start_o   : first cycle of a beat
//   sck_toggle_o   : SCK flips at the end of this cycle (after floor(P/2) cycles)
//   beat_last_o    : last cycle of a beat
module psram_beat_gen (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       active_i,
    input  logic [7:0] beat_len_i,
    output logic       beat_start_o,
    output logic       sck_toggle_o,
    output logic       beat_last_o
);

    logic [7:0] divCnt_q;
    logic [7:0] halfLen;

    assign halfLen      = {1'b0, beat_len_i[7:1]};
    assign beat_start_o = active_i && (divCnt_q == 8'd0);
    assign sck_toggle_o = active_i && (divCnt_q == halfLen - 8'd1);
    assign beat_last_o  = active_i && (divCnt_q == beat_len_i - 8'd1);

    // Free-running within a frame so beats follow each other without gaps
    // across phase boundaries.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            divCnt_q <= 8'd0;
        end else if (!active_i || beat_last_o) begin
            divCnt_q <= 8'd0;
        end else begin
            divCnt_q <= divCnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/psram_opi_engine.sv
// PSRAM OPI DDR transaction engine.
// Serialises one 32-bit word request into a CMD/ADDR/WAIT/DATA frame on the
// pad signals and returns a one-cycle response pulse.
//   clk_i, rst_i                  : clock, async active-high reset
//   en_i, pscr_i, cmd_i, wait_i   : configuration, latched at accept
//   req_*                         : request handshake (ready only in IDLE)
//   rsp_valid_o/rdata_o/err_o     : completion pulse, read data, disabled-drop flag
//   psram_*                       : pad interface (SCK, CE#, IO[7:0], DQS)
module psram_opi_engine
    import psram_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [7:0]            pscr_i,
    input  logic [15:0]           cmd_i,
    input  logic [7:0]            wait_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  psram_sck_o,
    output logic                  psram_ce_o,
    output logic [7:0]            psram_io_en_o,
    output logic [7:0]            psram_io_out_o,
    input  logic [7:0]            psram_io_in_i,
    output logic                  psram_dqs_en_o,
    output logic                  psram_dqs_out_o,
    input  logic                  psram_dqs_in_i
);

    state_e          state_q, state_d;
    logic            we_q;
    logic [3:0][7:0] addr_q;
    logic [3:0][7:0] wdata_q;
    logic [3:0][7:0] rdata_q;
    logic [7:0]      beatLen_q;
    logic [7:0]      wait_q;
    logic [7:0]      opcode_q;
    logic [8:0]      beatCnt_q;
    logic            sck_q;
    logic            errPulse_q;

    logic       beatStart, sckToggle, beatLast;
    logic       reqAccept, inFrame, stateDone, frameRsp;
    logic [8:0] lastBeat;
    logic [1:0] byteSel;

    // Byte address bits and DQS input are not needed: the engine works on
    // aligned words and captures read data on the system clock.
    logic unusedInputs;
    assign unusedInputs = ^{psram_dqs_in_i, req_addr_i[1:0]};

    assign reqAccept = req_valid_i && (state_q == IDLE);
    assign inFrame   = (state_q == CMD) || (state_q == ADDR) ||
                       (state_q == WAIT) || (state_q == DATA);
    assign stateDone = beatLast && (beatCnt_q == lastBeat);
    assign byteSel   = beatCnt_q[1:0];

    psram_beat_gen u_beat_gen (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .active_i     (state_q != IDLE),
        .beat_len_i   (beatLen_q),
        .beat_start_o (beatStart),
        .sck_toggle_o (sckToggle),
        .beat_last_o  (beatLast)
    );

    // Index of the final beat of the current phase.
    always_comb begin
        lastBeat = 9'd0;
        unique case (state_q)
            CMD:     lastBeat = CMD_BEATS - 9'd1;
            ADDR:    lastBeat = ADDR_BEATS - 9'd1;
            WAIT:    lastBeat = {wait_q, 1'b0} - 9'd1;
            DATA:    lastBeat = DATA_BEATS - 9'd1;
            RECOV:   lastBeat = RECOV_BEATS - 9'd1;
            default: lastBeat = 9'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; WAIT is skipped entirely for zero latency.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (reqAccept && en_i) state_d = CMD;
            CMD:     if (stateDone) state_d = ADDR;
            ADDR:    if (stateDone) state_d = (wait_q == 8'd0) ? DATA : WAIT;
            WAIT:    if (stateDone) state_d = DATA;
            DATA:    if (stateDone) state_d = RECOV;
            RECOV:   if (stateDone) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pad outputs; IO is only driven with data while its enable is set.
    always_comb begin
        psram_ce_o      = 1'b1;
        psram_io_en_o   = 8'h00;
        psram_io_out_o  = 8'h00;
        psram_dqs_en_o  = 1'b0;
        psram_dqs_out_o = 1'b0;
        unique case (state_q)
            CMD: begin
                psram_ce_o     = 1'b0;
                psram_io_en_o  = 8'hFF;
                psram_io_out_o = opcode_q;
            end
            ADDR: begin
                psram_ce_o     = 1'b0;
                psram_io_en_o  = 8'hFF;
                psram_io_out_o = addr_q[2'd3 - byteSel];
            end
            WAIT: begin
                psram_ce_o    = 1'b0;
                psram_io_en_o = we_q ? 8'hFF : 8'h00;
            end
            DATA: begin
                psram_ce_o = 1'b0;
                if (we_q) begin
                    psram_io_en_o  = 8'hFF;
                    psram_io_out_o = wdata_q[byteSel];
                    psram_dqs_en_o = 1'b1;
                end
            end
            default: begin
                psram_ce_o = 1'b1;
            end
        endcase
    end

    // Request latch, beat bookkeeping and read capture on the last cycle
    // of each DATA beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            beatLen_q  <= MIN_PSCR;
            wait_q     <= 8'd0;
            opcode_q   <= 8'd0;
            beatCnt_q  <= 9'd0;
            errPulse_q <= 1'b0;
        end else begin
            errPulse_q <= reqAccept && !en_i;
            if (reqAccept && en_i) begin
                we_q      <= req_we_i;
                addr_q    <= {req_addr_i[31:2], 2'b00};
                wdata_q   <= req_wdata_i;
                rdata_q   <= '0;
                beatLen_q <= beatLen(pscr_i);
                wait_q    <= wait_i;
                opcode_q  <= req_we_i ? cmd_i[7:0] : cmd_i[15:8];
            end
            if (state_d != state_q) begin
                beatCnt_q <= 9'd0;
            end else if (beatLast) begin
                beatCnt_q <= beatCnt_q + 9'd1;
            end
            if ((state_q == DATA) && !we_q && beatLast) begin
                rdata_q[byteSel] <= psram_io_in_i;
            end
        end
    end

    // SCK only runs inside a frame; every phase has an even beat count so
    // it is already low when CE rises.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_q <= 1'b0;
        end else if (!inFrame) begin
            sck_q <= 1'b0;
        end else if (sckToggle) begin
            sck_q <= ~sck_q;
        end
    end

    // Frame completion is the opening cycle of the first RECOV beat.
    assign frameRsp    = (state_q == RECOV) && beatStart && (beatCnt_q == 9'd0);
    assign rsp_valid_o = frameRsp || errPulse_q;
    assign rsp_err_o   = errPulse_q;
    assign rsp_rdata_o = (frameRsp && !we_q) ? rdata_q : '0;
    assign req_ready_o = (state_q == IDLE);
    assign psram_sck_o = sck_q;

endmodule
